// File: rtl/can_tx_scheduler.sv
// CAN transmit mailbox scheduler: offers the lowest-ID pending frame to tx_container,
// tracks the txing handshake, retries on loss and reports done/fail per mailbox.
module can_tx_scheduler #(
  parameter int unsigned NUM_MB    = 4,
  parameter int unsigned IDXW      = 2,
  parameter int unsigned MAX_RETRY = 8,
  parameter int unsigned START_TMO = 1023
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              mb_wr,
  input  logic              mb_abort,
  input  logic [IDXW-1:0]   mb_idx,
  input  logic [10:0]       mb_id,
  input  logic [63:0]       mb_data,
  output logic [NUM_MB-1:0] mb_pending,
  output logic              wr_rej,
  output logic              done,
  output logic              fail,
  output logic [IDXW-1:0]   done_idx,
  output logic [10:0]       tx_address,
  output logic [63:0]       tx_data,
  output logic              send_data,
  input  logic              txing,
  input  logic              tx_ack,
  input  logic              tx_lost,
  output logic              busy
);

  localparam int unsigned TMOW = $clog2(START_TMO + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state, state_n;
  logic [10:0]     id_q    [NUM_MB];
  logic [63:0]     data_q  [NUM_MB];
  logic [3:0]      retry_q [NUM_MB];
  logic [IDXW-1:0] act_q;
  logic [TMOW-1:0] tmo_q, tmo_n;

  logic            win_vld;
  logic [IDXW-1:0] win_idx;
  logic [10:0]     win_id;
  logic            latch, loss, ack_ok, drop, req, hit_act;
  logic [3:0]      ret_inc;

  // Lowest ID wins; strict compare in ascending index order keeps ties on the lowest index.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_id  = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (mb_pending[i] && (!win_vld || id_q[i] < win_id)) begin
        win_vld = 1'b1;
        win_idx = IDXW'(i);
        win_id  = id_q[i];
      end
    end
  end

  always_comb begin
    state_n = state;
    tmo_n   = tmo_q;
    latch   = 1'b0;
    loss    = 1'b0;
    ack_ok  = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld && !txing) begin
          latch   = 1'b1;
          state_n = START;
        end
      end
      START: begin
        tmo_n   = '0;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (txing) begin
          state_n = WAIT_DONE;
        end else if (tmo_q == TMOW'(START_TMO)) begin
          loss    = 1'b1;
          state_n = IDLE;
        end else begin
          tmo_n = tmo_q + TMOW'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_ack) begin
          ack_ok  = 1'b1;
          state_n = IDLE;
        end else if (tx_lost || !txing) begin
          loss    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ret_inc = (retry_q[act_q] == 4'hF) ? 4'hF : retry_q[act_q] + 4'd1;
  assign drop    = loss && (ret_inc == 4'(MAX_RETRY));
  assign req     = mb_wr || mb_abort;
  // The winner being latched this cycle already counts as active.
  assign hit_act = ((state != IDLE) && (mb_idx == act_q)) || (latch && (mb_idx == win_idx));

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      tmo_q      <= '0;
      act_q      <= '0;
      tx_address <= '0;
      tx_data    <= '0;
      send_data  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      done_idx   <= '0;
      wr_rej     <= 1'b0;
    end else begin
      state     <= state_n;
      tmo_q     <= tmo_n;
      send_data <= (state_n == START);
      busy      <= (state_n != IDLE);
      done      <= ack_ok;
      fail      <= drop;
      wr_rej    <= req && hit_act;
      if (ack_ok || drop) done_idx <= act_q;
      if (latch) begin
        act_q      <= win_idx;
        tx_address <= win_id;
        tx_data    <= data_q[win_idx];
      end
    end
  end

  // Mailbox storage; host writes never touch the active mailbox, so no conflict with FSM updates.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      mb_pending <= '0;
      for (int i = 0; i < NUM_MB; i++) begin
        id_q[i]    <= '0;
        data_q[i]  <= '0;
        retry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MB; i++) begin
        if (ack_ok && act_q == IDXW'(i)) mb_pending[i] <= 1'b0;
        if (loss && act_q == IDXW'(i)) begin
          retry_q[i] <= ret_inc;
          if (drop) mb_pending[i] <= 1'b0;
        end
        if (req && !hit_act && mb_idx == IDXW'(i)) begin
          if (mb_abort) begin
            mb_pending[i] <= 1'b0;
          end else begin
            id_q[i]       <= mb_id;
            data_q[i]     <= mb_data;
            retry_q[i]    <= '0;
            mb_pending[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule
